// File: rtl/mem_ctrl_line.sv
// Byte-serial memory controller arbitrating LSB transactions and icache line
// fills onto a byte-wide RAM with registered-read timing.
module mem_ctrl_line #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    LINE_BYTES   = 16,
  parameter int                    TAG_W        = 4,
  parameter int                    STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR      = 'h30000
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_aout,
  output logic                    mem_rw,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [31:0]             lsb_wdata,
  input  logic [1:0]              lsb_size,
  input  logic                    lsb_signed,
  input  logic [TAG_W-1:0]        lsb_tag,
  output logic                    lsb_ack,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  output logic [TAG_W-1:0]        lsb_done_tag,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_ack,
  output logic                    ic_valid,
  output logic [8*LINE_BYTES-1:0] ic_line,
  output logic [ADDR_WIDTH-1:0]   ic_line_addr,
  output logic                    busy
);

  localparam int KW = $clog2(LINE_BYTES) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IC_FILL, DRAIN, DONE} state_t;

  state_t                  state;
  logic                    is_ic, is_wr, sgn_q;
  logic [1:0]              size_q;
  logic [KW-1:0]           k, last;
  logic [ADDR_WIDTH-1:0]   base, aout_q, line_addr_q;
  logic [31:0]             wdata_q, rdata_q;
  logic [TAG_W-1:0]        tag_q;
  logic [8*LINE_BYTES-1:0] lbuf, line_q, line_full;
  logic [SW-1:0]           starve;

  logic                    issue_st, issuing, arb, io_hold, lsb_ok, grant_ic, grant_lsb;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [KW-1:0]           lsb_last;
  logic [31:0]             word, ld_ext;

  assign issue_st = (state == LSB_RD) || (state == LSB_WR) || (state == IC_FILL);
  assign issuing  = rdy_in && issue_st;
  assign cur_addr = base + ADDR_WIDTH'(k);

  // Held IO store stays pending without blocking a waiting fill.
  assign arb       = rst_in && rdy_in && !flush && (state == IDLE);
  assign io_hold   = lsb_we && (lsb_addr == IO_ADDR) && io_buffer_full;
  assign lsb_ok    = lsb_req && !io_hold;
  assign grant_ic  = arb && ic_req && (!lsb_ok || (starve == SW'(STARVE_LIMIT)));
  assign grant_lsb = arb && lsb_ok && !grant_ic;

  always_comb begin
    case (lsb_size)
      2'd0:    lsb_last = KW'(0);
      2'd1:    lsb_last = KW'(1);
      default: lsb_last = KW'(3);
    endcase
  end

  // Last byte arrives on mem_din in DRAIN; merge it before committing.
  always_comb begin
    line_full = lbuf;
    for (int i = 0; i < LINE_BYTES; i++)
      if (KW'(i) == last) line_full[8*i +: 8] = mem_din;
  end

  assign word = line_full[31:0];

  always_comb begin
    case (size_q)
      2'd0:    ld_ext = {{24{sgn_q & word[7]}},  word[7:0]};
      2'd1:    ld_ext = {{16{sgn_q & word[15]}}, word[15:0]};
      default: ld_ext = word;
    endcase
  end

  assign mem_aout     = issuing ? cur_addr : ((state == IDLE) ? '0 : aout_q);
  assign mem_rw       = issuing && (state == LSB_WR);
  assign mem_dout     = mem_rw ? wdata_q[{k[1:0], 3'b000} +: 8] : 8'h00;
  assign lsb_ack      = grant_lsb;
  assign ic_ack       = grant_ic;
  assign lsb_done     = (state == DONE) && rdy_in && !is_ic && (is_wr || !flush);
  assign ic_valid     = (state == DONE) && rdy_in && is_ic && !flush;
  assign lsb_done_tag = lsb_done ? tag_q : '0;
  assign lsb_rdata    = rdata_q;
  assign ic_line      = line_q;
  assign ic_line_addr = line_addr_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state       <= IDLE;
      is_ic       <= 1'b0;
      is_wr       <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= '0;
      k           <= '0;
      last        <= '0;
      base        <= '0;
      aout_q      <= '0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tag_q       <= '0;
      lbuf        <= '0;
      line_q      <= '0;
      starve      <= '0;
    end else if (rdy_in) begin
      if (issuing) aout_q <= cur_addr;
      if (!ic_req || grant_ic) starve <= '0;
      else if (grant_lsb)      starve <= starve + SW'(1);
      case (state)
        IDLE: begin
          if (grant_ic) begin
            is_ic <= 1'b1;
            is_wr <= 1'b0;
            base  <= ic_addr & ~LINE_MASK;
            k     <= '0;
            last  <= KW'(LINE_BYTES - 1);
            state <= IC_FILL;
          end else if (grant_lsb) begin
            is_ic   <= 1'b0;
            is_wr   <= lsb_we;
            base    <= lsb_addr;
            wdata_q <= lsb_wdata;
            size_q  <= lsb_size;
            sgn_q   <= lsb_signed;
            tag_q   <= lsb_tag;
            k       <= '0;
            last    <= lsb_last;
            state   <= lsb_we ? LSB_WR : LSB_RD;
          end
        end
        LSB_RD, IC_FILL: begin
          if (flush) state <= IDLE;
          else begin
            // mem_din now holds the byte issued in the previous active cycle
            for (int i = 0; i < LINE_BYTES; i++)
              if (KW'(i + 1) == k) lbuf[8*i +: 8] <= mem_din;
            if (k == last) state <= DRAIN;
            else           k     <= k + KW'(1);
          end
        end
        LSB_WR: begin
          if (k == last) state <= DONE;
          else           k     <= k + KW'(1);
        end
        DRAIN: begin
          if (flush) state <= IDLE;
          else begin
            if (is_ic) begin
              line_q      <= line_full;
              line_addr_q <= base;
            end else begin
              rdata_q <= ld_ext;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_line.sv
// Bench for mem_ctrl_line: directed literal cases plus random traffic checked
// every cycle against a phase-counting transaction model and a byte RAM.
module tb_mem_ctrl_line;
  localparam int SL = 4;

  logic         clk = 0, rst_in = 0, rdy_in = 1, flush = 0, io_buffer_full = 0;
  logic [7:0]   mem_din = 0, mem_dout;
  logic [31:0]  mem_aout;
  logic         mem_rw;
  logic         lsb_req = 0, lsb_we = 0, lsb_signed = 0;
  logic [31:0]  lsb_addr = 0, lsb_wdata = 0;
  logic [1:0]   lsb_size = 0;
  logic [3:0]   lsb_tag = 0, lsb_done_tag;
  logic         lsb_ack, lsb_done;
  logic [31:0]  lsb_rdata;
  logic         ic_req = 0, ic_ack, ic_valid, busy;
  logic [31:0]  ic_addr = 0, ic_line_addr;
  logic [127:0] ic_line;

  mem_ctrl_line #(.ADDR_WIDTH(32), .LINE_BYTES(16), .TAG_W(4), .STARVE_LIMIT(SL),
                  .IO_ADDR(32'h30000)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_aout(mem_aout), .mem_rw(mem_rw), .lsb_req(lsb_req), .lsb_we(lsb_we),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_size(lsb_size),
    .lsb_signed(lsb_signed), .lsb_tag(lsb_tag), .lsb_ack(lsb_ack),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .lsb_done_tag(lsb_done_tag),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_valid(ic_valid),
    .ic_line(ic_line), .ic_line_addr(ic_line_addr), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Sparse byte RAM with registered read; unwritten bytes have a fixed pattern.
  logic [7:0] ram [logic [31:0]];
  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  logic [31:0] a_s = 0;
  logic        rw_s = 0;
  logic [7:0]  d_s = 0;
  always @(negedge clk) begin
    a_s = mem_aout; rw_s = mem_rw; d_s = mem_dout;
  end
  always @(posedge clk) begin
    mem_din <= rd(a_s);
    if (rw_s) ram[a_s] = d_s;
  end

  // Transaction model: phase q counts active cycles since accept.
  bit           chk_en = 0;
  bit           m_busy = 0, m_ic = 0, m_we = 0;
  int           m_q = 0, m_n = 0, m_starve = 0;
  logic [31:0]  m_base = 0, m_rd = 0, m_wd = 0, m_last = 0, m_rdata = 0, m_laddr = 0;
  logic [127:0] m_line = 0, m_lineo = 0;
  logic [3:0]   m_tag = 0;

  always @(negedge clk) begin : model
    logic [31:0] e_aout, raw, mask;
    logic [7:0]  e_dout;
    bit          e_rw, e_ld, e_iv, e_lack, e_iack, issue, rd_txn, elig, lok;
    int          donep;
    if (chk_en) begin
      e_aout = 0; e_dout = 0; e_rw = 0; e_ld = 0; e_iv = 0; e_lack = 0; e_iack = 0;
      issue = 0; rd_txn = 0; donep = 0;
      if (!m_busy) begin
        elig = rst_in && rdy_in && !flush;
        lok  = lsb_req && !(lsb_we && lsb_addr == 32'h30000 && io_buffer_full);
        if (elig && ic_req && (!lok || m_starve == SL)) e_iack = 1;
        else if (elig && lok) e_lack = 1;
      end else begin
        issue  = rdy_in && (m_q < m_n);
        rd_txn = m_ic || !m_we;
        donep  = rd_txn ? m_n + 1 : m_n;
        if (issue) begin
          e_aout = m_base + 32'(m_q);
          e_rw   = m_we;
          e_dout = m_we ? m_wd[8*m_q +: 8] : 8'h00;
        end else e_aout = m_last;
        if (rdy_in && m_q == donep) begin
          e_ld = !m_ic && !(flush && rd_txn);
          e_iv = m_ic && !flush;
        end
      end
      chk("busy", busy, m_busy);
      chk("lsb_ack", lsb_ack, e_lack);
      chk("ic_ack", ic_ack, e_iack);
      chk("mem_aout", mem_aout, e_aout);
      chk("mem_rw", mem_rw, e_rw);
      chk("mem_dout", mem_dout, e_dout);
      chk("lsb_done", lsb_done, e_ld);
      chk("ic_valid", ic_valid, e_iv);
      chk("lsb_done_tag", lsb_done_tag, e_ld ? m_tag : 4'h0);
      chk("lsb_rdata", lsb_rdata, m_rdata);
      chk("ic_line", ic_line, m_lineo);
      chk("ic_line_addr", ic_line_addr, m_laddr);

      if (!rst_in) begin
        m_busy = 0; m_starve = 0; m_last = 0; m_rdata = 0; m_lineo = 0; m_laddr = 0;
      end else if (rdy_in) begin
        if (issue) m_last = e_aout;
        if (!ic_req || e_iack) m_starve = 0;
        else if (e_lack) m_starve++;
        if (!m_busy) begin
          if (e_iack) begin
            m_busy = 1; m_ic = 1; m_we = 0; m_q = 0; m_n = 16;
            m_base = ic_addr & ~32'hF;
            for (int i = 0; i < 16; i++) m_line[8*i +: 8] = rd(m_base + 32'(i));
          end else if (e_lack) begin
            m_busy = 1; m_ic = 0; m_we = lsb_we; m_q = 0;
            m_n = (lsb_size == 0) ? 1 : (lsb_size == 1) ? 2 : 4;
            m_base = lsb_addr; m_wd = lsb_wdata; m_tag = lsb_tag;
            raw = 0;
            for (int i = 0; i < m_n; i++) raw[8*i +: 8] = rd(m_base + 32'(i));
            mask = (m_n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*m_n)) - 1);
            m_rd = (lsb_signed && raw[8*m_n-1]) ? (raw | ~mask) : raw;
          end
        end else if (rd_txn && flush) begin
          m_busy = 0;
        end else begin
          if (rd_txn && m_q == m_n) begin
            if (m_ic) begin m_lineo = m_line; m_laddr = m_base; end
            else m_rdata = m_rd;
          end
          if (m_q == donep) m_busy = 0;
          else m_q++;
        end
      end
    end
  end

  task automatic wait_ack(input bit ic, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ic ? ic_ack : lsb_ack) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk(ic ? "ic_ack_timeout" : "lsb_ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic lsb_op(input bit we, input logic [31:0] addr, wd, input logic [1:0] sz,
                        input bit sg, input logic [3:0] tg, input int fl_at, p_at, p_len,
                        output int lat, output logic [31:0] data, output logic [3:0] tag_o);
    bit ok; int t; logic [31:0] pa;
    lat = -1; data = 0; tag_o = 0;
    lsb_req = 1; lsb_we = we; lsb_addr = addr; lsb_wdata = wd;
    lsb_size = sz; lsb_signed = sg; lsb_tag = tg;
    wait_ack(0, ok);
    t = cyc; pa = mem_aout;
    for (int k = 1; ok && k <= 40; k++) begin
      @(posedge clk); #1;
      lsb_req = 0;
      rdy_in  = !(p_len > 0 && k >= p_at && k < p_at + p_len);
      flush   = (k == fl_at);
      @(negedge clk);
      if (!rdy_in) begin
        chk("pause_rw", mem_rw, 0);
        chk("pause_aout", mem_aout, pa);
      end
      pa = mem_aout;
      if (lsb_done) begin lat = cyc - t; data = lsb_rdata; tag_o = lsb_done_tag; break; end
    end
    @(posedge clk); #1;
    lsb_req = 0; rdy_in = 1; flush = 0;
  endtask

  task automatic ic_op(input logic [31:0] addr, input int fl_at, output int lat,
                       output bit idle_after, output logic [127:0] line, output logic [31:0] la);
    bit ok; int t;
    lat = -1; idle_after = 0; line = 0; la = 0;
    ic_req = 1; ic_addr = addr;
    wait_ack(1, ok);
    t = cyc;
    for (int k = 1; ok && k <= 30; k++) begin
      @(posedge clk); #1;
      ic_req = 0;
      flush  = (k == fl_at);
      @(negedge clk);
      if (fl_at > 0 && k == fl_at + 1) idle_after = !busy;
      if (ic_valid) begin lat = cyc - t; line = ic_line; la = ic_line_addr; break; end
    end
    @(posedge clk); #1;
    ic_req = 0; flush = 0;
  endtask

  initial begin
    int lat; logic [31:0] data, la; logic [3:0] tg; bit ia, ok;
    logic [127:0] line; logic [7:0] d2; logic [5:0] seq; int ng, nl, ni;

    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h80;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_in = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", lsb_rdata, 0);
    chk("rst_line", ic_line, 0);
    chk("rst_aout", mem_aout, 0);
    @(posedge clk); #1;

    lsb_op(0, 32'h100, 0, 2'd2, 0, 4'd5, 0, 0, 0, lat, data, tg);
    chk("word_lat", lat, 6); chk("word_data", data, 32'h80332211); chk("word_tag", tg, 5);
    lsb_op(0, 32'h103, 0, 2'd0, 1, 4'd1, 0, 0, 0, lat, data, tg);
    chk("sbyte_lat", lat, 3); chk("sbyte_data", data, 32'hFFFFFF80);
    lsb_op(0, 32'h102, 0, 2'd1, 0, 4'd2, 0, 0, 0, lat, data, tg);
    chk("uhalf_lat", lat, 4); chk("uhalf_data", data, 32'h00008033);

    lsb_op(1, 32'h200, 32'hDEADBEEF, 2'd2, 0, 4'd3, 2, 0, 0, lat, data, tg);
    chk("store_lat", lat, 5); chk("store_tag", tg, 3);
    chk("store_ram", {rd(32'h203), rd(32'h202), rd(32'h201), rd(32'h200)}, 32'hDEADBEEF);

    ic_op(32'h1234, 0, lat, ia, line, la);
    chk("fill_lat", lat, 18); chk("fill_addr", la, 32'h1230);
    chk("fill_b0", line[7:0], rd(32'h1230)); chk("fill_b15", line[127:120], rd(32'h123F));
    ic_op(32'h1234, 5, lat, ia, line, la);
    chk("fill_flush_novalid", lat == -1, 1); chk("fill_flush_idle", ia, 1);

    // reset in the middle of a store: later bytes never reach RAM
    d2 = rd(32'h302);
    lsb_req = 1; lsb_we = 1; lsb_addr = 32'h300; lsb_wdata = 32'hCAFEF00D; lsb_size = 2;
    wait_ack(0, ok);
    @(posedge clk); #1; lsb_req = 0;
    @(posedge clk); #1; rst_in = 0;
    @(posedge clk); #1; rst_in = 1;
    @(negedge clk);
    chk("midrst_busy", busy, 0); chk("midrst_rdata", lsb_rdata, 0); chk("midrst_line", ic_line, 0);
    @(posedge clk); #1;
    chk("midrst_ram", {rd(32'h302), rd(32'h301), rd(32'h300)}, {d2, 16'hF00D});

    // starvation guard
    seq = 0; ng = 0;
    ic_req = 1; ic_addr = 32'h5000; lsb_req = 1; lsb_we = 0; lsb_size = 0; lsb_addr = 32'h100;
    for (int i = 0; i < 200 && ng < 6; i++) begin
      @(negedge clk);
      if (lsb_ack) begin seq = {seq[4:0], 1'b0}; ng++; end
      if (ic_ack)  begin seq = {seq[4:0], 1'b1}; ng++; end
      @(posedge clk); #1;
    end
    lsb_req = 0; ic_req = 0;
    chk("starve_grants", ng, 6); chk("starve_seq", seq, 6'b000010);
    wait_idle();

    // IO hold with a pending fill
    nl = 0; ni = 0;
    io_buffer_full = 1; lsb_req = 1; lsb_we = 1; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    lsb_size = 0; ic_req = 1; ic_addr = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nl += int'(lsb_ack); ni += int'(ic_ack);
      @(posedge clk); #1;
      if (ni > 0) ic_req = 0;
    end
    io_buffer_full = 0;
    chk("io_no_ack", nl, 0); chk("io_ic_served", ni, 1);
    wait_ack(0, ok);
    chk("io_ack_after", ok, 1);
    @(posedge clk); #1; lsb_req = 0;
    wait_idle();
    chk("io_ram", rd(32'h30000), 8'h41);

    lsb_op(0, 32'h100, 0, 2'd2, 0, 4'd7, 0, 2, 2, lat, data, tg);
    chk("pause_lat", lat, 8); chk("pause_data", data, 32'h80332211); chk("pause_tag", tg, 7);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst_in         = ($urandom % 500) != 0;
      rdy_in         = ($urandom % 8) != 0;
      flush          = ($urandom % 16) == 0;
      io_buffer_full = $urandom % 2;
      lsb_req        = ($urandom % 3) != 0;
      lsb_we         = $urandom % 2;
      case ($urandom % 4)
        0:       lsb_addr = 32'h30000;
        1:       lsb_addr = 32'h100 + ($urandom % 16);
        2:       lsb_addr = 32'hFFFF_FFFC + ($urandom % 4);
        default: lsb_addr = $urandom;
      endcase
      lsb_size   = 2'($urandom % 4);
      lsb_signed = $urandom % 2;
      lsb_tag    = 4'($urandom);
      lsb_wdata  = $urandom;
      ic_req     = ($urandom % 3) == 0;
      ic_addr    = ($urandom % 2) ? $urandom : 32'h1000 + ($urandom % 64);
    end
    rst_in = 1; rdy_in = 1; flush = 0; lsb_req = 0; ic_req = 0; io_buffer_full = 0;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_line.md
# mem_ctrl_line

Byte-serial main-memory controller arbitrating between the load/store buffer and the instruction cache, successor to the single-word controller. It generalises instruction fetch to whole cache lines (`LINE_BYTES`), adds tagged LSB transactions with explicit accept/done handshakes, and adds a starvation guard for fetch. It also defines flush and pause behaviour precisely, including under a stalled I/O buffer. It sits between the LSB/icache and the external byte RAM (`mem_din`/`mem_dout`/`mem_aout`/`mem_rw`).

## Interface
- `ADDR_WIDTH`, 32, address width.
- `LINE_BYTES`, 16, icache line size in bytes; power of 2, ≥4.
- `TAG_W`, 4, LSB transaction tag width.
- `STARVE_LIMIT`, 4, consecutive LSB grants allowed while `ic_req` waits.
- `IO_ADDR`, 32'h30000, I/O output port address.

Ports:
- `clk` — in, 1. Single clock.
- `rst_in` — in, 1. Synchronous, active-low reset.
- `rdy_in` — in, 1. 0 pauses the block.
- `flush` — in, 1. Mispredict flush.
- `io_buffer_full` — in, 1. I/O output buffer full.
- `mem_din` — in, 8. RAM read byte; valid the cycle after its address.
- `mem_dout` — out, 8. RAM write byte.
- `mem_aout` — out, ADDR_WIDTH. RAM address.
- `mem_rw` — out, 1. 1 = write.
- `lsb_req` — in, 1. LSB request.
- `lsb_we` — in, 1. LSB store.
- `lsb_addr` — in, ADDR_WIDTH. LSB address.
- `lsb_wdata` — in, 32. Store data.
- `lsb_size` — in, 2. 0 = byte, 1 = half, 2 = word.
- `lsb_signed` — in, 1. Sign-extend load.
- `lsb_tag` — in, TAG_W. Transaction tag.
- `lsb_ack` — out, 1. Request accepted this cycle.
- `lsb_done` — out, 1. One-cycle completion pulse.
- `lsb_rdata` — out, 32. Load result.
- `lsb_done_tag` — out, TAG_W. Tag of completing transaction.
- `ic_req` — in, 1. Line-fill request.
- `ic_addr` — in, ADDR_WIDTH. Fill address.
- `ic_ack` — out, 1. Fill accepted this cycle.
- `ic_valid` — out, 1. One-cycle line-ready pulse.
- `ic_line` — out, 8*LINE_BYTES. Line data, byte 0 in bits [7:0].
- `ic_line_addr` — out, ADDR_WIDTH. Line base address.
- `busy` — out, 1. State ≠ IDLE.

## Operation
- States:
  - IDLE
  - LSB_RD, LSB_WR, IC_FILL (issue phases)
  - DRAIN (capture last read byte)
  - DONE (pulse outputs)
- Transfer size N:
  - LSB: 1, 2 or 4 bytes per `lsb_size`; `lsb_size`=3 is treated as 4.
  - Fill: N = `LINE_BYTES`.
- Byte order and addressing:
  - Bytes are issued at base, base+1, …, base+N-1, little-endian.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - Fill base is `ic_addr` with the low log2(LINE_BYTES) bits cleared.
- Arbitration in IDLE, only when `rdy_in`=1 and `flush`=0:
  - LSB has priority.
  - Exception: grant icache when `ic_req` is high and the starvation counter = `STARVE_LIMIT`.
  - The counter increments on each LSB grant while `ic_req` is high.
  - The counter clears on an icache grant or whenever `ic_req` is low.
- I/O hold: `lsb_req & lsb_we & lsb_addr==IO_ADDR & io_buffer_full` is not acked. `ic_req` may be granted meanwhile.
- Accept: `lsb_ack` or `ic_ack` pulses in the accept cycle. Address, data, size, sign and tag are registered.
- Reads: `mem_din` is captured into byte k in the cycle after byte k was issued.
- Load result:
  - Zero- or sign-extended from bit 8N-1.
  - Registered in `lsb_rdata`, which holds until the next load completes.
- Writes: `mem_rw`=1 only in LSB_WR issue cycles, with `mem_dout` = `lsb_wdata` byte k.
- Idle bus: `mem_aout`=0, `mem_rw`=0, `mem_dout`=0.
- Flush:
  - IDLE: no grant that cycle.
  - LSB_RD, IC_FILL, DRAIN or DONE of a read: abort to IDLE next cycle with no `lsb_done`/`ic_valid`. This includes suppressing a pulse due that cycle.
  - LSB_WR: the store is never aborted. It completes and `lsb_done` still pulses.
- Pause (`rdy_in`=0):
  - All state frozen; `mem_rw` forced to 0; `mem_aout` holds the last issued address.
  - On resume, a pending read byte is captured from `mem_din`, which still reflects the held address.
  - No write is ever repeated.
- Reset (`rst_in`=0 at posedge):
  - State goes to IDLE; the starvation counter clears.
  - All outputs go to 0, including `lsb_rdata`, `ic_line` and `ic_line_addr`.
  - Reset mid-operation discards the transaction, including a partial store.

## Timing
- Accept at cycle t. Bytes are issued in t+1 … t+N, one per cycle.
- Load: byte N-1 is captured in DRAIN at t+N+1; `lsb_done` with valid data at t+N+2.
  - Latency N+2 cycles: byte 3, word 6.
- Store: last write at t+N; `lsb_done` at t+N+1.
- Fill: `ic_valid` with `ic_line` and `ic_line_addr` at t+LINE_BYTES+2.
- Back-to-back: IDLE is re-entered the cycle after DONE, so the next accept is at the earliest DONE+1.
- `busy`=1 from t+1 through the DONE cycle.
- Each pause cycle extends all of the above by exactly one cycle.

## Test plan
- Word load: RAM[0x100..0x103]=0x11,0x22,0x33,0x80; LSB load word tag 5 at 0x100.
  - `lsb_ack` at t.
  - `lsb_done` at t+6 with `lsb_rdata`=0x80332211 and `lsb_done_tag`=5.
- Signed byte/half loads at 0x103: byte signed → 0xFFFFFF80 at t+3; half unsigned at 0x102 → 0x00008033.
- Word store 0xDEADBEEF to 0x200:
  - `mem_rw`=1 at t+1..t+4 with `mem_dout` EF, BE, AD, DE.
  - `lsb_done` at t+5.
  - `flush` at t+2 does not abort the store.
- Line fill, LINE_BYTES=16, `ic_addr`=0x1234:
  - Bytes issued 0x1230..0x123F.
  - `ic_valid` at t+18 with `ic_line_addr`=0x1230.
  - `flush` at t+5 instead gives no `ic_valid`, IDLE at t+6.
- Starvation: `ic_req` held high plus continuous LSB byte loads. Exactly 4 LSB grants, then one `ic_ack`, then LSB grants resume.
- I/O hold and pause:
  - Store to 0x30000 with `io_buffer_full`=1 for 3 cycles: no `lsb_ack` until `io_buffer_full` falls, and a pending `ic_req` is served meanwhile.
  - `rdy_in`=0 for 2 cycles during a word load: `lsb_done` is 2 cycles late with correct data.
  - During the pause, `mem_rw`=0 and `mem_aout` is unchanged.
